// File: rtl/voice_alloc_pkg.sv
// voice_alloc_pkg -- shared types and constants for the voice allocator.
//   state_t     : allocator FSM state encoding
//   AGE_BITS    : width of each voice's age counter
//   AGE_MAX     : saturation value of the age counter
//   vclass_t    : classification of a voice from its gate and envelope flag
//   tgt_kind_t  : which priority rule selected the note-on target
package voice_alloc_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SCAN     = 2'd1,
    GATE_LOW = 2'd2,
    COMMIT   = 2'd3
  } state_t;

  localparam int AGE_BITS = 8;
  localparam logic [AGE_BITS-1:0] AGE_MAX = 8'd255;

  typedef enum logic [1:0] {
    VC_FREE      = 2'd0,  // gate 0, envelope idle
    VC_RELEASING = 2'd1,  // gate 0, envelope still sounding
    VC_HELD      = 2'd2   // gate 1
  } vclass_t;

  typedef enum logic [2:0] {
    TGT_RETRIG  = 3'd0,
    TGT_FREE    = 3'd1,
    TGT_RELEASE = 3'd2,
    TGT_STEAL   = 3'd3,
    TGT_DROP    = 3'd4
  } tgt_kind_t;

  function automatic vclass_t classify(input logic gate, input logic active);
    if (gate)        return VC_HELD;
    else if (active) return VC_RELEASING;
    else             return VC_FREE;
  endfunction

endpackage

// File: rtl/voice_slot.sv
// voice_slot -- state of one voice: envelope gate, held note and age.
// Ports:
//   clk, rst         : clock, asynchronous active-high reset
//   gate_set         : assign the voice (gate 1, latch note_wr)
//   gate_clr         : drop the gate (note is kept)
//   note_wr          : note number to store on gate_set
//   age_clr, age_inc : clear / saturating-increment the age counter
//   gate, note, age  : current voice state
module voice_slot
  import voice_alloc_pkg::*;
#(
  parameter int NOTE_BITS = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 gate_set,
  input  logic                 gate_clr,
  input  logic [NOTE_BITS-1:0] note_wr,
  input  logic                 age_clr,
  input  logic                 age_inc,
  output logic                 gate,
  output logic [NOTE_BITS-1:0] note,
  output logic [AGE_BITS-1:0]  age
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gate <= 1'b0;
      note <= '0;
      age  <= '0;
    end else begin
      if (gate_set)      gate <= 1'b1;
      else if (gate_clr) gate <= 1'b0;

      // The note outlives the gate so a releasing voice still reports it.
      if (gate_set) note <= note_wr;

      if (age_clr)                        age <= '0;
      else if (age_inc && age != AGE_MAX) age <= age + 1'b1;
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// voice_allocator -- assigns note-on/note-off events to NUM_VOICES envelope
// voices. Each accepted event scans all voices one per cycle, then commits.
// Note-on priority: retrigger equal held note, lowest free voice, oldest
// releasing voice, oldest held voice (steal). Age ties go to lowest index.
// Ports:
//   clk, reset     : clock, asynchronous active-high reset
//   note_valid/ready, note_on, note_num : event handshake and payload
//   voice_active   : per-voice envelope-active flags from the envelopes
//   gate           : per-voice envelope gate
//   voice_note     : note per voice, voice i at [i*NOTE_BITS +: NOTE_BITS]
//   steal, dropped : one-cycle status pulses in the COMMIT cycle
// Configuration: define VOICE_ALLOC_STEAL_EN to enable stealing of held
// voices; otherwise a note-on with no candidate is dropped.
module voice_allocator
  import voice_alloc_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int NOTE_BITS  = 7
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            note_valid,
  output logic                            note_ready,
  input  logic                            note_on,
  input  logic [NOTE_BITS-1:0]            note_num,
  input  logic [NUM_VOICES-1:0]           voice_active,
  output logic [NUM_VOICES-1:0]           gate,
  output logic [NUM_VOICES*NOTE_BITS-1:0] voice_note,
  output logic                            steal,
  output logic                            dropped
);

  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  typedef logic [IDX_W-1:0] idx_t;

  state_t state, state_nxt;
  idx_t   scan_idx;
  logic   scan_last;

  logic                 ev_on;
  logic [NOTE_BITS-1:0] ev_note;

  // Best candidate seen so far in each priority class.
  logic                rt_found, fr_found, rl_found, hd_found;
  idx_t                rt_idx, fr_idx, rl_idx, hd_idx;
  logic [AGE_BITS-1:0] rl_age, hd_age;
  logic                rt_found_n, fr_found_n, rl_found_n, hd_found_n;
  idx_t                rt_idx_n, fr_idx_n, rl_idx_n, hd_idx_n;
  logic [AGE_BITS-1:0] rl_age_n, hd_age_n;

  tgt_kind_t tgt_kind, tgt_kind_n;
  idx_t      tgt_idx, tgt_idx_n;

  logic [NOTE_BITS-1:0] slot_note [NUM_VOICES];
  logic [AGE_BITS-1:0]  slot_age  [NUM_VOICES];

  vclass_t              cur_class;
  logic [NOTE_BITS-1:0] cur_note;
  logic [AGE_BITS-1:0]  cur_age;

  logic commit, on_commit;

  assign note_ready = (state == IDLE);
  assign scan_last  = (scan_idx == idx_t'(NUM_VOICES - 1));
  assign commit     = (state == COMMIT);
  assign on_commit  = commit && ev_on && (tgt_kind != TGT_DROP);

  // The voice under examination; voice_active is sampled only in its slot.
  assign cur_class = classify(gate[scan_idx], voice_active[scan_idx]);
  assign cur_note  = slot_note[scan_idx];
  assign cur_age   = slot_age[scan_idx];

  // NOTE: every output of a combinational block is given a default first,
  // so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    rt_found_n = rt_found; rt_idx_n = rt_idx;
    fr_found_n = fr_found; fr_idx_n = fr_idx;
    rl_found_n = rl_found; rl_idx_n = rl_idx; rl_age_n = rl_age;
    hd_found_n = hd_found; hd_idx_n = hd_idx; hd_age_n = hd_age;
    if (state == SCAN) begin
      case (cur_class)
        VC_HELD: begin
          if (ev_on && cur_note == ev_note && !rt_found) begin
            rt_found_n = 1'b1;
            rt_idx_n   = scan_idx;
          end
          // Strict compare: on equal age the earlier (lower) index is kept.
          if (!hd_found || cur_age > hd_age) begin
            hd_found_n = 1'b1;
            hd_idx_n   = scan_idx;
            hd_age_n   = cur_age;
          end
        end
        VC_RELEASING: begin
          if (!rl_found || cur_age > rl_age) begin
            rl_found_n = 1'b1;
            rl_idx_n   = scan_idx;
            rl_age_n   = cur_age;
          end
        end
        default: begin
          if (!fr_found) begin
            fr_found_n = 1'b1;
            fr_idx_n   = scan_idx;
          end
        end
      endcase
    end
  end

  // Target resolution uses the updated candidates so the last voice counts.
  always_comb begin
    tgt_kind_n = TGT_DROP;
    tgt_idx_n  = '0;
    if (rt_found_n) begin
      tgt_kind_n = TGT_RETRIG;
      tgt_idx_n  = rt_idx_n;
    end else if (fr_found_n) begin
      tgt_kind_n = TGT_FREE;
      tgt_idx_n  = fr_idx_n;
    end else if (rl_found_n) begin
      tgt_kind_n = TGT_RELEASE;
      tgt_idx_n  = rl_idx_n;
    end else if (hd_found_n) begin
`ifdef VOICE_ALLOC_STEAL_EN
      tgt_kind_n = TGT_STEAL;
      tgt_idx_n  = hd_idx_n;
`else
      tgt_kind_n = TGT_DROP;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (note_valid) state_nxt = SCAN;
      SCAN: begin
        if (scan_last) begin
          // A target that is already gated needs a low cycle first so the
          // envelope sees a new rising edge.
          if (ev_on && (tgt_kind_n == TGT_RETRIG || tgt_kind_n == TGT_STEAL))
            state_nxt = GATE_LOW;
          else
            state_nxt = COMMIT;
        end
      end
      GATE_LOW: state_nxt = COMMIT;
      COMMIT:   state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      scan_idx <= '0;
      ev_on    <= 1'b0;
      ev_note  <= '0;
      rt_found <= 1'b0; rt_idx <= '0;
      fr_found <= 1'b0; fr_idx <= '0;
      rl_found <= 1'b0; rl_idx <= '0; rl_age <= '0;
      hd_found <= 1'b0; hd_idx <= '0; hd_age <= '0;
      tgt_kind <= TGT_DROP;
      tgt_idx  <= '0;
    end else begin
      state    <= state_nxt;
      rt_found <= rt_found_n; rt_idx <= rt_idx_n;
      fr_found <= fr_found_n; fr_idx <= fr_idx_n;
      rl_found <= rl_found_n; rl_idx <= rl_idx_n; rl_age <= rl_age_n;
      hd_found <= hd_found_n; hd_idx <= hd_idx_n; hd_age <= hd_age_n;
      if (state == IDLE && note_valid) begin
        ev_on    <= note_on;
        ev_note  <= note_num;
        scan_idx <= '0;
        rt_found <= 1'b0;
        fr_found <= 1'b0;
        rl_found <= 1'b0;
        hd_found <= 1'b0;
      end
      if (state == SCAN) begin
        if (scan_last) begin
          tgt_kind <= tgt_kind_n;
          tgt_idx  <= tgt_idx_n;
        end else begin
          scan_idx <= scan_idx + 1'b1;
        end
      end
    end
  end

`ifdef VOICE_ALLOC_STEAL_EN
  assign steal   = on_commit && (tgt_kind == TGT_STEAL);
  assign dropped = 1'b0;
`else
  assign steal   = 1'b0;
  assign dropped = commit && ev_on && (tgt_kind == TGT_DROP);
`endif

  for (genvar i = 0; i < NUM_VOICES; i++) begin : g_slot
    logic sel, set_i, clr_i;
    assign sel   = (tgt_idx == idx_t'(i));
    assign set_i = on_commit && sel;
    // Note-off clears every held voice carrying the note.
    assign clr_i = (state == GATE_LOW && sel) ||
                   (commit && !ev_on && gate[i] && slot_note[i] == ev_note);

    voice_slot #(.NOTE_BITS(NOTE_BITS)) u_slot (
      .clk      (clk),
      .rst      (reset),
      .gate_set (set_i),
      .gate_clr (clr_i),
      .note_wr  (ev_note),
      .age_clr  (set_i),
      .age_inc  (on_commit && !sel),
      .gate     (gate[i]),
      .note     (slot_note[i]),
      .age      (slot_age[i])
    );

    assign voice_note[i*NOTE_BITS +: NOTE_BITS] = slot_note[i];
  end

endmodule

// File: tb/tb_voice_allocator.sv
// tb_voice_allocator -- self-checking bench for voice_allocator (4 voices).
// A behavioural voice model (arrays of gate/note/age plus a priority search)
// predicts every event's target, latency, pulses and resulting voice state.
module tb_voice_allocator;

  localparam int NV = 4;
  localparam int NB = 7;
`ifdef VOICE_ALLOC_STEAL_EN
  localparam bit STEAL_EN = 1'b1;
`else
  localparam bit STEAL_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             note_valid;
  logic             note_ready;
  logic             note_on;
  logic [NB-1:0]    note_num;
  logic [NV-1:0]    voice_active;
  logic [NV-1:0]    gate;
  logic [NV*NB-1:0] voice_note;
  logic             steal;
  logic             dropped;

  int n_checks = 0;
  int n_fail   = 0;

  bit m_gate [NV];
  int m_note [NV];
  int m_age  [NV];

  always #5 clk = ~clk;

  voice_allocator #(.NUM_VOICES(NV), .NOTE_BITS(NB)) dut (
    .clk          (clk),
    .reset        (reset),
    .note_valid   (note_valid),
    .note_ready   (note_ready),
    .note_on      (note_on),
    .note_num     (note_num),
    .voice_active (voice_active),
    .gate         (gate),
    .voice_note   (voice_note),
    .steal        (steal),
    .dropped      (dropped)
  );

  function automatic int vnote(input int i);
    return int'(voice_note[i*NB +: NB]);
  endfunction

  function automatic logic [NV-1:0] model_gates();
    logic [NV-1:0] g;
    for (int i = 0; i < NV; i++) g[i] = m_gate[i];
    return g;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NV; i++) begin
      m_gate[i] = 1'b0; m_note[i] = 0; m_age[i] = 0;
    end
  endtask

  // kind: 0 retrigger, 1 free, 2 releasing, 3 steal, 4 drop
  task automatic model_pick(input int num, input logic [NV-1:0] va,
                            output int kind, output int idx);
    int best;
    kind = 4; idx = 0; best = -1;
    for (int i = 0; i < NV; i++)
      if (best < 0 && m_gate[i] && m_note[i] == num) best = i;
    if (best >= 0) begin kind = 0; idx = best; return; end
    for (int i = 0; i < NV; i++)
      if (best < 0 && !m_gate[i] && !va[i]) best = i;
    if (best >= 0) begin kind = 1; idx = best; return; end
    for (int i = 0; i < NV; i++)
      if (!m_gate[i] && va[i] && (best < 0 || m_age[i] > m_age[best])) best = i;
    if (best >= 0) begin kind = 2; idx = best; return; end
    if (STEAL_EN) begin
      for (int i = 0; i < NV; i++)
        if (m_gate[i] && (best < 0 || m_age[i] > m_age[best])) best = i;
      kind = 3; idx = best;
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1; note_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // Runs one event from a negedge and compares everything against the model.
  // flip_mask is XORed into voice_active at the negedge numbered flip_lat.
  task automatic do_event(input bit on, input int num, input string tag,
                          input int flip_lat = 0, input logic [NV-1:0] flip_mask = '0);
    int kind, idx, lat, exp_lat, n_steal, n_drop, w, exp_low;
    int low [NV];
    bit pre [NV];
    kind = 5; idx = 0;
    if (on) model_pick(num, voice_active, kind, idx);
    exp_lat = NV + 2 + ((on && (kind == 0 || kind == 3)) ? 1 : 0);
    pre = m_gate;
    w = 0;
    while (!note_ready && w < 50) begin @(negedge clk); w++; end
    note_valid = 1'b1; note_on = on; note_num = NB'(num);
    @(posedge clk);
    @(negedge clk);
    note_valid = 1'b0;
    lat = 1; n_steal = 0; n_drop = 0;
    for (int i = 0; i < NV; i++) low[i] = 0;
    forever begin
      if (lat == flip_lat) voice_active = voice_active ^ flip_mask;
      if (steal)   n_steal++;
      if (dropped) n_drop++;
      for (int i = 0; i < NV; i++) if (pre[i] && !gate[i]) low[i]++;
      if (note_ready || lat >= 40) break;
      @(negedge clk);
      lat++;
    end
    if (on) begin
      if (kind <= 3) begin
        for (int j = 0; j < NV; j++) m_age[j] = (j == idx) ? 0 : ((m_age[j] < 255) ? m_age[j] + 1 : 255);
        m_gate[idx] = 1'b1; m_note[idx] = num;
      end
    end else begin
      for (int j = 0; j < NV; j++) if (m_gate[j] && m_note[j] == num) m_gate[j] = 1'b0;
    end
    n_checks++;
    if (lat !== exp_lat) begin
      n_fail++; $display("FAIL %s latency: got %0d expected %0d", tag, lat, exp_lat);
    end
    n_checks++;
    if (n_steal !== ((kind == 3) ? 1 : 0)) begin
      n_fail++; $display("FAIL %s steal pulses: got %0d expected %0d", tag, n_steal, (kind == 3) ? 1 : 0);
    end
    n_checks++;
    if (n_drop !== ((kind == 4) ? 1 : 0)) begin
      n_fail++; $display("FAIL %s dropped pulses: got %0d expected %0d", tag, n_drop, (kind == 4) ? 1 : 0);
    end
    if (on) begin
      for (int j = 0; j < NV; j++) begin
        if (pre[j]) begin
          exp_low = ((kind == 0 || kind == 3) && j == idx) ? 1 : 0;
          n_checks++;
          if (low[j] !== exp_low) begin
            n_fail++; $display("FAIL %s gate%0d low cycles: got %0d expected %0d", tag, j, low[j], exp_low);
          end
        end
      end
    end
    n_checks++;
    if (gate !== model_gates()) begin
      n_fail++; $display("FAIL %s gate: got %b expected %b", tag, gate, model_gates());
    end
    for (int j = 0; j < NV; j++) begin
      n_checks++;
      if (vnote(j) !== m_note[j]) begin
        n_fail++; $display("FAIL %s voice_note[%0d]: got %0d expected %0d", tag, j, vnote(j), m_note[j]);
      end
    end
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if (gate !== 4'b0000 || voice_note !== '0) begin
      n_fail++; $display("FAIL reset voices: got gate %b notes %h expected 0", gate, voice_note);
    end
    n_checks++;
    if (note_ready !== 1'b1 || steal !== 1'b0 || dropped !== 1'b0) begin
      n_fail++; $display("FAIL reset status: got ready %b steal %b dropped %b expected 1 0 0",
                         note_ready, steal, dropped);
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_basic();
    voice_active = '0;
    do_event(1'b1, 60, "basic_on60");
    n_checks++;
    if (gate !== 4'b0001 || vnote(0) !== 60) begin
      n_fail++; $display("FAIL basic: got gate %b note0 %0d expected 0001 60", gate, vnote(0));
    end
  endtask

  task automatic test_note_off();
    do_event(1'b1, 62, "off_on62");
    do_event(1'b1, 64, "off_on64");
    do_event(1'b1, 65, "off_on65");
    n_checks++;
    if (gate !== 4'b1111) begin
      n_fail++; $display("FAIL four_held: got %b expected 1111", gate);
    end
    do_event(1'b0, 62, "off62");
    n_checks++;
    if (gate !== 4'b1101 || vnote(1) !== 62) begin
      n_fail++; $display("FAIL off62: got gate %b note1 %0d expected 1101 62", gate, vnote(1));
    end
    do_event(1'b0, 70, "off70_nomatch");
    n_checks++;
    if (gate !== 4'b1101) begin
      n_fail++; $display("FAIL off70: got %b expected 1101", gate);
    end
  endtask

  task automatic test_steal();
    apply_reset();
    voice_active = 4'b1111;
    do_event(1'b1, 60, "st_on60");
    do_event(1'b1, 62, "st_on62");
    do_event(1'b1, 64, "st_on64");
    do_event(1'b1, 65, "st_on65");
    do_event(1'b1, 67, "st_on67");
    n_checks++;
    if (gate !== 4'b1111 || vnote(0) !== (STEAL_EN ? 67 : 60)) begin
      n_fail++; $display("FAIL steal: got gate %b note0 %0d expected 1111 %0d",
                         gate, vnote(0), STEAL_EN ? 67 : 60);
    end
  endtask

  task automatic test_release();
    apply_reset();
    voice_active = 4'b0000;
    do_event(1'b1, 60, "rl_on60");
    do_event(1'b1, 62, "rl_on62");
    do_event(1'b1, 64, "rl_on64");
    do_event(1'b1, 65, "rl_on65");
    do_event(1'b0, 62, "rl_off62");
    voice_active = 4'b1111;
    do_event(1'b1, 50, "rl_on50");
    n_checks++;
    if (gate !== 4'b1111 || vnote(1) !== 50) begin
      n_fail++; $display("FAIL release: got gate %b note1 %0d expected 1111 50", gate, vnote(1));
    end
  endtask

  task automatic test_retrigger();
    apply_reset();
    voice_active = 4'b0000;
    do_event(1'b1, 10, "rt_on10");
    do_event(1'b1, 20, "rt_on20");
    do_event(1'b1, 60, "rt_on60");
    do_event(1'b1, 60, "rt_retrig60");
    n_checks++;
    if (gate !== 4'b0111 || vnote(2) !== 60 || vnote(3) !== 0) begin
      n_fail++; $display("FAIL retrigger: got gate %b note2 %0d note3 %0d expected 0111 60 0",
                         gate, vnote(2), vnote(3));
    end
  endtask

  // voice 0 reads free when examined; turning it active afterwards is ignored
  task automatic test_active_sample();
    apply_reset();
    voice_active = 4'b0000;
    do_event(1'b1, 10, "as_on10");
    do_event(1'b1, 20, "as_on20");
    do_event(1'b0, 10, "as_off10");
    do_event(1'b1, 30, "as_on30", 2, 4'b0001);
    n_checks++;
    if (vnote(0) !== 30 || gate !== 4'b0011) begin
      n_fail++; $display("FAIL active_sample: got gate %b note0 %0d expected 0011 30", gate, vnote(0));
    end
  endtask

  task automatic test_reset_mid();
    note_valid = 1'b1; note_on = 1'b1; note_num = 7'd99;
    @(posedge clk);
    @(negedge clk);
    note_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++;
    if (gate !== 4'b0000 || note_ready !== 1'b1 || voice_note !== '0) begin
      n_fail++; $display("FAIL reset_mid: got gate %b ready %b notes %h expected 0000 1 0",
                         gate, note_ready, voice_note);
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    repeat (10) @(negedge clk);
    n_checks++;
    if (gate !== 4'b0000 || voice_note !== '0 || note_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid_after: got gate %b notes %h ready %b expected 0000 0 1",
                         gate, voice_note, note_ready);
    end
  endtask

  task automatic test_random();
    int num;
    bit on;
    apply_reset();
    for (int k = 0; k < 250; k++) begin
      voice_active = NV'($urandom);
      on = ($urandom_range(0, 99) < 65);
      num = 60 + $urandom_range(0, 7);
      do_event(on, num, "random");
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; note_valid = 1'b0; note_on = 1'b0; note_num = '0;
    voice_active = '0;
    test_reset();
    test_basic();
    test_note_off();
    test_steal();
    test_release();
    test_retrigger();
    test_reset_mid();
    test_active_sample();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
